// File: rtl/life_pkg.sv
// life_pkg: shared state encoding and seed constants for the Life seed controller
package life_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RAND  = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3
  } state_t;
  localparam logic [63:0] DEF_SEED = 64'h0412_6424_0034_3C28;
  localparam logic [63:0] DEF_TAPS = 64'hD800_0000_0000_0000;
endpackage

// File: rtl/lfsr_galois.sv
// lfsr_galois: free-running right-shift Galois LFSR with all-zero lockup recovery
module lfsr_galois
  import life_pkg::*;
#(
  parameter int               WIDTH = 64,
  parameter logic [WIDTH-1:0] TAPS  = DEF_TAPS[WIDTH-1:0],
  parameter logic [WIDTH-1:0] INIT  = DEF_SEED[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] lfsr
);
  always_ff @(posedge clk or posedge reset)
    if (reset) lfsr <= INIT;
    else lfsr <= (lfsr == '0) ? INIT : (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
endmodule

// File: rtl/life_seed_ctrl.sv
// life_seed_ctrl: seed register, play/pause FSM and generation step divider for the Life grid
module life_seed_ctrl
  import life_pkg::*;
#(
  parameter int          GRID_W       = 64,
  parameter logic [63:0] LFSR_TAPS    = DEF_TAPS,
  parameter logic [63:0] DEFAULT_SEED = DEF_SEED,
  parameter int          TICK_DIV     = 4,
  parameter int          GEN_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              randomize,
  input  logic              load,
  input  logic              pause,
  input  logic [GRID_W-1:0] input_seed,
  output logic [GRID_W-1:0] output_seed,
  output logic              seed_valid,
  output logic              step,
  output logic [GEN_W-1:0]  gen_count,
  output logic [2:0]        state_o
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [GRID_W-1:0] SEED0 = DEFAULT_SEED[GRID_W-1:0];
  logic [GRID_W-1:0] lfsr;
  logic [CW-1:0] cnt;
  state_t state, nxt;
  logic wrap, stay, wr;
  lfsr_galois #(
    .WIDTH(GRID_W),
    .TAPS (LFSR_TAPS[GRID_W-1:0]),
    .INIT (SEED0)
  ) u_lfsr (
    .clk  (clk),
    .reset(reset),
    .lfsr (lfsr)
  );
  always_comb begin
    nxt  = randomize ? RAND :
           load ? IDLE :
           (start && state != PLAY) ? PLAY :
           (pause && state == PLAY) ? PAUSE : state;
    wrap = cnt == CW'(TICK_DIV - 1);
    stay = state == PLAY && nxt == PLAY;
    wr   = randomize | load;
  end
  assign state_o = state;
  // the divider only advances on cycles that both start and end in PLAY, so leaving PLAY never emits a step
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= IDLE;
      output_seed <= SEED0;
      seed_valid  <= 1'b0;
      step        <= 1'b0;
      gen_count   <= '0;
      cnt         <= '0;
    end else begin
      state      <= nxt;
      seed_valid <= wr;
      step       <= stay && wrap;
      if (wr) begin
        output_seed <= randomize ? lfsr : (input_seed == '0 ? SEED0 : input_seed);
        cnt         <= '0;
        gen_count   <= '0;
      end else if (stay) begin
        cnt <= wrap ? '0 : cnt + 1'b1;
        if (wrap && !(&gen_count)) gen_count <= gen_count + 1'b1;
      end
    end
endmodule

// File: tb/tb_life_seed_ctrl.sv
// tb_life_seed_ctrl: directed checks of seeding, play/pause stepping and saturation
module tb_life_seed_ctrl;
  localparam logic [63:0] D0 = 64'h0412_6424_0034_3C28;
  localparam logic [63:0] D1 = 64'h0209_3212_001A_1E14;
  localparam logic [63:0] D2 = 64'h0104_9909_000D_0F0A;
  logic        clk = 0, reset = 1;
  logic        start = 0, randomize = 0, load = 0, pause = 0;
  logic [63:0] input_seed = '0;
  logic [63:0] seed_a, seed_b;
  logic        valid_a, valid_b, step_a, step_b;
  logic [3:0]  gen_a;
  logic [15:0] gen_b;
  logic [2:0]  st_a, st_b;
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  life_seed_ctrl #(.TICK_DIV(4), .GEN_W(4)) dut_a (
    .clk(clk), .reset(reset), .start(start), .randomize(randomize), .load(load),
    .pause(pause), .input_seed(input_seed), .output_seed(seed_a), .seed_valid(valid_a),
    .step(step_a), .gen_count(gen_a), .state_o(st_a)
  );
  life_seed_ctrl #(.TICK_DIV(1), .GEN_W(16)) dut_b (
    .clk(clk), .reset(reset), .start(start), .randomize(randomize), .load(load),
    .pause(pause), .input_seed(input_seed), .output_seed(seed_b), .seed_valid(valid_b),
    .step(step_b), .gen_count(gen_b), .state_o(st_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1; start = 0; randomize = 0; load = 0; pause = 0; input_seed = '0;
    repeat (2) tick;
    reset = 0;
  endtask

  initial begin
    do_reset;
    repeat (5) tick;
    chk("rst_seed", seed_a, D0);
    chk("rst_state", 64'(st_a), 0);
    chk("rst_step", 64'(step_a), 0);
    chk("rst_valid", 64'(valid_a), 0);
    chk("rst_gen", 64'(gen_a), 0);
    chk("rst_state_b", 64'(st_b), 0);

    do_reset;
    tick;
    randomize = 1;
    tick;
    chk("rand1_seed", seed_a, D1);
    chk("rand1_valid", 64'(valid_a), 1);
    chk("rand1_state", 64'(st_a), 1);
    tick;
    chk("rand2_seed", seed_a, D2);
    chk("rand2_valid", 64'(valid_a), 1);
    randomize = 0;
    tick;
    chk("rand_valid_drop", 64'(valid_a), 0);
    chk("rand_hold_state", 64'(st_a), 1);
    chk("rand_hold_seed", seed_a, D2);

    load = 1; input_seed = 64'hFF;
    tick;
    chk("load_seed", seed_a, 64'hFF);
    chk("load_state", 64'(st_a), 0);
    chk("load_valid", 64'(valid_a), 1);
    input_seed = '0;
    tick;
    chk("load0_seed", seed_a, D0);
    load = 0;
    tick;
    chk("load_valid_drop", 64'(valid_a), 0);

    start = 1;
    tick;
    chk("start_state", 64'(st_a), 2);
    for (int i = 1; i <= 20; i++) begin
      tick;
      chk($sformatf("play_step_%0d", i), 64'(step_a), (i % 4 == 0) ? 64'd1 : 64'd0);
      chk($sformatf("div1_step_%0d", i), 64'(step_b), 1);
    end
    chk("play_gen", 64'(gen_a), 5);
    chk("div1_gen", 64'(gen_b), 20);
    start = 0;

    load = 1; input_seed = 64'hFF;
    tick;
    load = 0;
    chk("reload_gen", 64'(gen_a), 0);
    start = 1;
    tick;
    start = 0;
    repeat (8) tick;
    chk("pre_pause_gen", 64'(gen_a), 2);
    chk("pre_pause_step", 64'(step_a), 1);
    tick;
    pause = 1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("pause_state_%0d", i), 64'(st_a), 3);
      chk($sformatf("pause_step_%0d", i), 64'(step_a), 0);
      chk($sformatf("pause_gen_%0d", i), 64'(gen_a), 2);
    end
    pause = 0; start = 1;
    tick;
    start = 0;
    chk("resume_state", 64'(st_a), 2);
    chk("resume_step", 64'(step_a), 0);
    tick;
    chk("resume_step_1", 64'(step_a), 0);
    tick;
    chk("resume_step_2", 64'(step_a), 0);
    tick;
    chk("resume_step_3", 64'(step_a), 1);
    chk("resume_gen", 64'(gen_a), 3);

    repeat (60) tick;
    chk("sat_gen", 64'(gen_a), 15);
    repeat (4) tick;
    chk("sat_gen_hold", 64'(gen_a), 15);

    randomize = 1;
    tick;
    randomize = 0;
    chk("play_rand_gen", 64'(gen_a), 0);
    chk("play_rand_step", 64'(step_a), 0);
    chk("play_rand_state", 64'(st_a), 1);
    chk("play_rand_valid", 64'(valid_a), 1);
    chk("play_rand_gen_b", 64'(gen_b), 0);
    chk("play_rand_step_b", 64'(step_b), 0);

    load = 1; input_seed = 64'hFF;
    tick;
    load = 0; start = 1;
    tick;
    start = 0;
    repeat (4) tick;
    chk("mid_step", 64'(step_a), 1);
    reset = 1;
    #1;
    chk("areset_step", 64'(step_a), 0);
    chk("areset_seed", seed_a, D0);
    chk("areset_gen", 64'(gen_a), 0);
    chk("areset_state", 64'(st_a), 0);
    chk("areset_valid", 64'(valid_a), 0);
    chk("areset_step_b", 64'(step_b), 0);
    tick;
    reset = 0;
    tick;
    chk("post_reset_step", 64'(step_a), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
